// File: rtl/mem_stage_pkg.sv
// Shared encodings and default widths for the memory pipeline stage.
package mem_stage_pkg;

  localparam int DEF_AW = 4;
  localparam int DEF_DW = 4;
  localparam int DEF_RW = 2;

  typedef enum logic [1:0] {
    OP_PASS  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_INC   = 2'b11
  } op_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_INC_WR = 1'b1
  } state_e;

endpackage

// File: rtl/mem_stage.sv
// Memory stage: one EX/MEM holding register in front of a synchronous-write data
// memory, with a two-cycle read-modify-write for INC.
//
// state     | meaning
// ST_RUN    | EX/MEM op executes this cycle; new instructions accepted
// ST_INC_WR | writing back the incremented value held in inc_q; no accept
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int RW = DEF_RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic [1:0]    ex_op,
  input  logic [AW-1:0] ex_addr,
  input  logic [DW-1:0] ex_wdata,
  input  logic [RW-1:0] ex_rd,
  output logic          ex_ready,
  input  logic          flush,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_di,
  input  logic [DW-1:0] dm_do,
  output logic          wb_valid,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic [7:0]    acc_cnt
);

  state_e        state, state_nxt;
  logic          exm_valid;
  op_e           exm_op;
  logic [AW-1:0] exm_addr;
  logic [DW-1:0] exm_data;
  logic [RW-1:0] exm_rd;
  logic [DW-1:0] inc_q;

  logic run_act, inc_start, inc_done, capture, mem_done, wb_load;

  always_comb begin
    state_nxt = state;
    ex_ready  = (state == ST_RUN);
    run_act   = (state == ST_RUN) && exm_valid;
    inc_start = run_act && (exm_op == OP_INC);
    inc_done  = (state == ST_INC_WR);
    capture   = ex_valid && ex_ready && !flush;
    mem_done  = (run_act && (exm_op == OP_LOAD || exm_op == OP_STORE)) || inc_done;
    wb_load   = (run_act && (exm_op == OP_LOAD || exm_op == OP_PASS)) || inc_done;
    if (inc_start) state_nxt = ST_INC_WR;
    if (inc_done)  state_nxt = ST_RUN;
  end

  // rst gates the strobe so an INC caught mid-write never reaches memory
  assign dm_we   = !rst && ((run_act && exm_op == OP_STORE) || inc_done);
  assign dm_addr = exm_addr;
  assign dm_di   = inc_done ? inc_q : exm_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      exm_valid <= 1'b0;
      exm_op    <= OP_PASS;
      exm_addr  <= '0;
      exm_data  <= '0;
      exm_rd    <= '0;
    end else begin
      state <= state_nxt;
      // an INC keeps its slot for the write cycle; the offer in that cycle is not taken
      if (!inc_start) begin
        exm_valid <= capture;
        if (capture) begin
          exm_op   <= op_e'(ex_op);
          exm_addr <= ex_addr;
          exm_data <= ex_wdata;
          exm_rd   <= ex_rd;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      inc_q    <= '0;
      acc_cnt  <= '0;
    end else begin
      wb_valid <= wb_load;
      if (wb_load) begin
        wb_rd <= exm_rd;
        if (inc_done)                   wb_data <= inc_q;
        else if (exm_op == OP_LOAD)     wb_data <= dm_do;
        else                            wb_data <= exm_data;
      end
      if (inc_start) inc_q <= dm_do + exm_data;
      if (mem_done && acc_cnt != 8'hFF) acc_cnt <= acc_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a behavioural data memory and
// hand-computed expected values.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       ex_valid;
  logic [1:0] ex_op;
  logic [3:0] ex_addr;
  logic [3:0] ex_wdata;
  logic [1:0] ex_rd;
  logic       ex_ready;
  logic       flush;
  logic       dm_we;
  logic [3:0] dm_addr;
  logic [3:0] dm_di;
  logic [3:0] dm_do;
  logic       wb_valid;
  logic [1:0] wb_rd;
  logic [3:0] wb_data;
  logic [7:0] acc_cnt;

  logic       mem_clr;
  logic       pl_we;
  logic [3:0] pl_addr;
  logic [3:0] pl_data;
  logic [3:0] mem [16];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .ex_ready(ex_ready), .flush(flush),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_di(dm_di), .dm_do(dm_do),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .acc_cnt(acc_cnt)
  );

  assign dm_do = mem[dm_addr];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 16; k++) mem[k] <= 4'h0;
    end else if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end else if (dm_we) begin
      mem[dm_addr] <= dm_di;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] a,
                       input logic [3:0] d, input logic [1:0] rd, input logic fl);
    ex_valid = v;
    ex_op    = op;
    ex_addr  = a;
    ex_wdata = d;
    ex_rd    = rd;
    flush    = fl;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 4'h0, 4'h0, 2'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mem_clr = 1'b1; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    idle();
    step();
    step();
    chk("rst_dm_we", dm_we, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_acc", acc_cnt, 0);
    chk("rst_ready", ex_ready, 1);
    mem_clr = 1'b0; pl_we = 1'b1; pl_addr = 4'h3; pl_data = 4'h5;
    step();
    pl_addr = 4'h7; pl_data = 4'hE;
    step();
    pl_we = 1'b0; rst = 1'b0;
    chk("post_rst_dm_we", dm_we, 0);

    // LOAD a=3 rd=1
    drive(1'b1, OP_LOAD, 4'h3, 4'h0, 2'd1, 1'b0);
    step();
    idle();
    chk("ld_dm_we", dm_we, 0);
    chk("ld_wb_early", wb_valid, 0);
    step();
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_rd", wb_rd, 1);
    chk("ld_wb_data", wb_data, 5);
    chk("ld_dm_we2", dm_we, 0);
    chk("ld_acc", acc_cnt, 1);
    step();
    chk("ld_wb_clear", wb_valid, 0);

    // STORE a=F d=A then LOAD a=F rd=2
    drive(1'b1, OP_STORE, 4'hF, 4'hA, 2'd0, 1'b0);
    step();
    chk("st_dm_we", dm_we, 1);
    chk("st_dm_addr", dm_addr, 15);
    chk("st_dm_di", dm_di, 10);
    drive(1'b1, OP_LOAD, 4'hF, 4'h0, 2'd2, 1'b0);
    step();
    idle();
    chk("st_pulse_end", dm_we, 0);
    chk("st_wb_valid", wb_valid, 0);
    chk("st_mem", mem[15], 10);
    step();
    chk("stld_wb_valid", wb_valid, 1);
    chk("stld_wb_data", wb_data, 10);
    chk("stld_wb_rd", wb_rd, 2);
    chk("stld_acc", acc_cnt, 3);

    // INC a=7 d=3 with M[7]=E wraps to 1
    drive(1'b1, OP_INC, 4'h7, 4'h3, 2'd3, 1'b0);
    step();
    idle();
    chk("inc_ready_run", ex_ready, 1);
    chk("inc_we_run", dm_we, 0);
    step();
    chk("inc_ready_wr", ex_ready, 0);
    chk("inc_we_wr", dm_we, 1);
    chk("inc_di", dm_di, 1);
    chk("inc_wb_early", wb_valid, 0);
    step();
    chk("inc_ready_back", ex_ready, 1);
    chk("inc_mem", mem[7], 1);
    chk("inc_wb_valid", wb_valid, 1);
    chk("inc_wb_data", wb_data, 1);
    chk("inc_wb_rd", wb_rd, 3);
    chk("inc_acc", acc_cnt, 4);
    chk("inc_we_done", dm_we, 0);

    // PASS d=9 rd=2
    drive(1'b1, OP_PASS, 4'h2, 4'h9, 2'd2, 1'b0);
    step();
    idle();
    chk("pass_we", dm_we, 0);
    step();
    chk("pass_wb_valid", wb_valid, 1);
    chk("pass_wb_data", wb_data, 9);
    chk("pass_acc", acc_cnt, 4);

    // flushed STORE a=2 d=9
    drive(1'b1, OP_STORE, 4'h2, 4'h9, 2'd0, 1'b1);
    step();
    idle();
    chk("fl_we", dm_we, 0);
    step();
    chk("fl_mem", mem[2], 0);
    chk("fl_acc", acc_cnt, 4);

    // flush during INC_WR: M[7]=1, +5 -> 6
    drive(1'b1, OP_INC, 4'h7, 4'h5, 2'd1, 1'b0);
    step();
    idle();
    step();
    drive(1'b1, OP_STORE, 4'h2, 4'h9, 2'd0, 1'b1);
    chk("flwr_we", dm_we, 1);
    step();
    idle();
    chk("flwr_mem", mem[7], 6);
    chk("flwr_wb_data", wb_data, 6);
    chk("flwr_wb_valid", wb_valid, 1);
    chk("flwr_acc", acc_cnt, 5);
    chk("flwr_no_store", dm_we, 0);

    // rst while in INC_WR: M[7]=6 must stay
    drive(1'b1, OP_INC, 4'h7, 4'h1, 2'd2, 1'b0);
    step();
    idle();
    step();
    chk("rstwr_ready", ex_ready, 0);
    rst = 1'b1;
    #1;
    chk("rstwr_we", dm_we, 0);
    step();
    rst = 1'b0;
    chk("rstwr_mem", mem[7], 6);
    chk("rstwr_wb_valid", wb_valid, 0);
    chk("rstwr_wb_data", wb_data, 0);
    chk("rstwr_wb_rd", wb_rd, 0);
    chk("rstwr_acc", acc_cnt, 0);
    chk("rstwr_ready1", ex_ready, 1);
    chk("rstwr_we1", dm_we, 0);

    // 260 back-to-back STOREs saturate acc_cnt
    for (int i = 0; i < 260; i++) begin
      if (i == 101) chk("sat_mid", acc_cnt, 100);
      drive(1'b1, OP_STORE, 4'(i), 4'(i + 1), 2'd0, 1'b0);
      step();
    end
    idle();
    step();
    chk("sat_255", acc_cnt, 255);
    chk("sat_mem_f", mem[15], 4'(255 + 1));
    step();
    step();
    chk("sat_hold", acc_cnt, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL provide parameter AW, default 4, giving the data-memory address width.
REQ-002 The block SHALL provide parameter DW, default 4, giving the data width.
REQ-003 The block SHALL provide parameter RW, default 2, giving the destination-register index width.
REQ-004 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-006 Ports ex_valid (1 bit), ex_op (2 bits), ex_addr (AW), ex_wdata (DW) and ex_rd (RW) SHALL be inputs: the instruction offered by the execute stage.
REQ-007 Port ex_ready SHALL be an output, 1 bit: the stage accepts the offered instruction this cycle.
REQ-008 Port flush SHALL be an input, 1 bit: kill the instruction offered this cycle.
REQ-009 Ports dm_we (1 bit), dm_addr (AW) and dm_di (DW) SHALL be outputs to data memory, whose write is synchronous.
REQ-010 Port dm_do SHALL be an input, DW bits: combinational read data of data memory at dm_addr.
REQ-011 Ports wb_valid (1 bit), wb_rd (RW) and wb_data (DW) SHALL be registered outputs to write-back.
REQ-012 Port acc_cnt SHALL be an output, 8 bits: saturating count of completed memory accesses.

Function
REQ-013 The op encoding SHALL be 00 PASS (wb_data=ex_wdata), 01 LOAD, 10 STORE, 11 INC (M[a] <= M[a]+ex_wdata, wb_data=new value).
REQ-014 The stage SHALL hold one instruction in an EX/MEM register, loaded on an edge where ex_valid=1, ex_ready=1 and flush=0; otherwise valid clears.
REQ-015 The FSM SHALL have two states, RUN and INC_WR, and ex_ready SHALL be 1 in RUN and 0 in INC_WR.
REQ-016 dm_addr SHALL equal the EX/MEM address, and dm_we SHALL be 0 unless a valid STORE is in RUN or the FSM is in INC_WR.
REQ-017 A STORE SHALL set dm_we=1 with dm_di=stored data for exactly one cycle, and SHALL produce wb_valid=0.
REQ-018 A LOAD SHALL register dm_do into wb_data on the next edge, with wb_valid=1 and wb_rd=EX/MEM rd.
REQ-019 A PASS SHALL register the data into wb_data on the next edge, with wb_valid=1 and no memory activity.
REQ-020 An INC in RUN SHALL register (dm_do+data) mod 2^DW into an inc register, enter INC_WR, and hold the EX/MEM register.
REQ-021 In INC_WR the stage SHALL drive dm_we=1 and dm_di=the inc register for one cycle, register wb_data=the inc register with wb_valid=1 on that edge, and return to RUN.
REQ-022 wb_valid SHALL be 0 on every edge not completing a PASS, LOAD or INC.
REQ-023 Latency from capture edge N SHALL be: LOAD/PASS wb at edge N+1; STORE written at edge N+1; INC written and wb at edge N+2.
REQ-024 flush SHALL NOT affect an INC already in INC_WR; it only suppresses capture, including an offer at the same edge as an INC completion.
REQ-025 Back-to-back STORE then LOAD to the same address SHALL return the stored value, with no forwarding logic.
REQ-026 acc_cnt SHALL increment by 1 per completed LOAD, STORE or INC (INC counted once, in INC_WR) and saturate at 255.
REQ-027 Address 2^AW-1 SHALL be accessed normally, and INC overflow SHALL wrap (F+1=0 for DW=4).

Reset
REQ-028 On rst the block SHALL set state=RUN, EX/MEM valid=0, wb_valid=0, wb_rd=0, wb_data=0, the inc register=0 and acc_cnt=0.
REQ-029 dm_we SHALL be 0 in the cycle rst is high and the cycle after it.
REQ-030 An INC interrupted by rst in INC_WR SHALL NOT write memory.

Structure
REQ-031 A shared package SHALL hold the op encodings, FSM state encodings and default widths.
REQ-032 The block SHALL contain no sub-module; the data memory SHALL be instantiated by the parent, with its display port driven elsewhere.

Verification
REQ-033 A bench SHALL check: memory preloaded M[3]=5, LOAD a=3 rd=1 -> wb_valid=1, wb_rd=1, wb_data=5 one edge after capture, dm_we=0 throughout.
REQ-034 A bench SHALL check: STORE a=F d=A, then LOAD a=F on the next cycle -> dm_we pulse of exactly 1 cycle, wb_data=A.
REQ-035 A bench SHALL check: M[7]=E, INC a=7 d=3 -> ex_ready low for 1 cycle, M[7]=1, wb_data=1, acc_cnt +1.
REQ-036 A bench SHALL check: flush=1 with a STORE offered -> no dm_we, acc_cnt unchanged; flush during INC_WR -> write still occurs.
REQ-037 A bench SHALL check: rst asserted while in INC_WR -> no memory write, all outputs at reset values next cycle.
REQ-038 A bench SHALL check: 260 consecutive STOREs -> acc_cnt=255 and holds.
